// File: rtl/mfp_botio_pkg.sv
// Shared constants for the multi-bot AHB-lite I/O peripheral: register
// offsets inside a channel, the global channel index, HTRANS encodings and
// STATUS bit positions.
package mfp_botio_pkg;

  // Register offsets within a channel (HADDR[3:2])
  localparam logic [1:0] BOTINFO = 2'd0;
  localparam logic [1:0] BOTCTRL = 2'd1;
  localparam logic [1:0] STATUS  = 2'd2;
  localparam logic [1:0] INTACK  = 2'd3;

  // Channel index of the global register bank (INTEN lives at offset 0)
  localparam logic [3:0] GLOBAL_CH = 4'hF;

  // HTRANS encodings that carry no transfer
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;

  // STATUS register bit positions
  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_OVR_BIT  = 1;

  // Registered address-phase word address, split into channel and register
  typedef struct packed {
    logic [3:0] ch;
    logic [1:0] rg;
  } reg_addr_t;

endpackage

// File: rtl/mfp_botio_sync_edge.sv
// Two-flop synchroniser for an asynchronous update level, followed by an
// edge flop; emits a one-cycle pulse on each synchronised rising edge.
module mfp_botio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;
  logic edge_d,  edge_q;

  // Next-state for the shift chain
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  // Synchroniser and edge-detect registers
  // NOTE: sequential state uses non-blocking assignments only, and all flops
  // take the async reset so the edge detector cannot fire a spurious pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  assign rise = sync2_q & ~edge_q;

endmodule

// File: rtl/mfp_ahb_botio.sv
// AHB-lite slave giving the core access to NUM_BOTS RojoBot channels:
// motor-control registers, bot-info words, and sticky update events with
// pending/overrun status, write-to-acknowledge and a merged interrupt.
module mfp_ahb_botio
  import mfp_botio_pkg::*;
#(
  parameter int NUM_BOTS = 2,
  parameter int CTRL_W   = 8
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic                       HSEL,
  input  logic                       HREADY,
  input  logic [31:0]                HWDATA,
  output logic [31:0]                HRDATA,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [NUM_BOTS*CTRL_W-1:0] IO_BotCtrl,
  input  logic [NUM_BOTS*32-1:0]     IO_BotInfo,
  input  logic [NUM_BOTS-1:0]        IO_BotUpdt,
  output logic [NUM_BOTS-1:0]        IO_INT_ACK,
  output logic                       IRQ
);

  logic      accept;
  reg_addr_t addr_d, addr_q;
  logic      write_d, write_q;
  logic      valid_d, valid_q;
  logic      wr_en, rd_en;

  logic [NUM_BOTS-1:0] inten_d, inten_q;
  logic [NUM_BOTS-1:0] pend_vec;
  logic [31:0]         chan_rd [NUM_BOTS];

  // Address bits outside the decoded window and unused write-data bits
  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR[31:8], HADDR[1:0], HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Capture the address phase; valid drops on any cycle without one
  always_comb begin
    accept  = HSEL & HREADY & (HTRANS != HTRANS_IDLE) & (HTRANS != HTRANS_BUSY);
    addr_d  = addr_q;
    write_d = write_q;
    valid_d = accept;
    if (accept) begin
      addr_d  = HADDR[7:2];
      write_d = HWRITE;
    end
  end

  // Address-phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      valid_q <= valid_d;
    end
  end

  assign wr_en = valid_q & write_q;
  assign rd_en = valid_q & ~write_q;

  // Global interrupt-enable register
  always_comb begin
    inten_d = inten_q;
    if (wr_en && addr_q.ch == GLOBAL_CH && addr_q.rg == BOTINFO)
      inten_d = HWDATA[NUM_BOTS-1:0];
  end

  // Interrupt-enable state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) inten_q <= '0;
    else          inten_q <= inten_d;
  end

  for (genvar c = 0; c < NUM_BOTS; c++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(c);

    logic              sel;
    logic              rise;
    logic              ack_hit;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              pend_d, pend_q;
    logic              ovr_d, ovr_q;
    logic              ack_d, ack_q;
    logic [31:0]       status_word;

    mfp_botio_sync_edge u_sync (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .async_in (IO_BotUpdt[c]),
      .rise     (rise)
    );

    assign sel = wr_en && (addr_q.ch == CH_IDX);

    // Control write, ack decode and sticky event status; a new edge beats
    // a simultaneous ack but still clears overrun
    always_comb begin
      ctrl_d  = ctrl_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      ack_hit = sel && (addr_q.rg == INTACK) && HWDATA[0];
      ack_d   = ack_hit;
      if (sel && addr_q.rg == BOTCTRL)
        ctrl_d = HWDATA[CTRL_W-1:0];
      if (rise) begin
        pend_d = 1'b1;
        ovr_d  = ack_hit ? 1'b0 : (ovr_q | pend_q);
      end else if (ack_hit) begin
        pend_d = 1'b0;
        ovr_d  = 1'b0;
      end
    end

    // Per-channel state
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        ctrl_q <= '0;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        ctrl_q <= ctrl_d;
        pend_q <= pend_d;
        ovr_q  <= ovr_d;
        ack_q  <= ack_d;
      end
    end

    // STATUS read word
    always_comb begin
      status_word                  = '0;
      status_word[STATUS_PEND_BIT] = pend_q;
      status_word[STATUS_OVR_BIT]  = ovr_q;
    end

    assign IO_BotCtrl[c*CTRL_W +: CTRL_W] = ctrl_q;
    assign IO_INT_ACK[c]                  = ack_q;
    assign pend_vec[c]                    = pend_q;
    assign chan_rd[c] = (addr_q.rg == BOTINFO) ? IO_BotInfo[c*32 +: 32] :
                        (addr_q.rg == BOTCTRL) ? 32'(ctrl_q)            :
                        (addr_q.rg == STATUS)  ? status_word            :
                                                 32'd0;
  end

  // Read mux from the registered address; zero outside a read data phase
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      if (addr_q.ch == GLOBAL_CH) begin
        if (addr_q.rg == BOTINFO) HRDATA = 32'(inten_q);
      end else begin
        for (int i = 0; i < NUM_BOTS; i++)
          if (addr_q.ch == 4'(i)) HRDATA = chan_rd[i];
      end
    end
  end

  assign IRQ = |(pend_vec & inten_q);

endmodule

// File: tb/tb_mfp_ahb_botio.sv
// Self-checking bench for mfp_ahb_botio (NUM_BOTS=2, CTRL_W=8): directed
// scenarios plus randomized bus traffic against a register-level model.
module tb_mfp_ahb_botio;

  localparam int NB = 2;
  localparam int CW = 8;

  logic              HCLK;
  logic              HRESETn;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic              HSEL;
  logic              HREADY;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [NB*CW-1:0]  IO_BotCtrl;
  logic [NB*32-1:0]  IO_BotInfo;
  logic [NB-1:0]     IO_BotUpdt;
  logic [NB-1:0]     IO_INT_ACK;
  logic              IRQ;

  mfp_ahb_botio #(.NUM_BOTS(NB), .CTRL_W(CW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .IO_BotCtrl (IO_BotCtrl),
    .IO_BotInfo (IO_BotInfo),
    .IO_BotUpdt (IO_BotUpdt),
    .IO_INT_ACK (IO_INT_ACK),
    .IRQ        (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total  = 0;
  int passed = 0;

  // Reference model: register contents as the software would see them
  logic [CW-1:0] m_ctrl [NB];
  logic [31:0]   m_info [NB];
  logic          m_pend [NB];
  logic          m_ovr  [NB];
  logic [NB-1:0] m_inten;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_ctrl[i] = '0;
      m_pend[i] = 1'b0;
      m_ovr[i]  = 1'b0;
    end
    m_inten = '0;
  endtask

  function automatic logic [31:0] model_read(input int ch, input int r);
    if (ch < NB) begin
      case (r)
        0:       return m_info[ch];
        1:       return 32'(m_ctrl[ch]);
        2:       return {30'd0, m_ovr[ch], m_pend[ch]};
        default: return 32'd0;
      endcase
    end
    if (ch == 15 && r == 0) return 32'(m_inten);
    return 32'd0;
  endfunction

  task automatic model_write(input int ch, input int r, input logic [31:0] d);
    if (ch < NB) begin
      if (r == 1) m_ctrl[ch] = d[CW-1:0];
      else if (r == 3 && d[0]) begin
        m_pend[ch] = 1'b0;
        m_ovr[ch]  = 1'b0;
      end
    end else if (ch == 15 && r == 0) begin
      m_inten = d[NB-1:0];
    end
  endtask

  // An update event; with_ack means an ack landed on the same edge
  task automatic model_edge(input int ch, input bit with_ack);
    if (with_ack) m_ovr[ch] = 1'b0;
    else          m_ovr[ch] = m_ovr[ch] | m_pend[ch];
    m_pend[ch] = 1'b1;
  endtask

  function automatic logic model_irq();
    for (int i = 0; i < NB; i++)
      if (m_pend[i] && m_inten[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_ctrl_bus();
    logic [NB*CW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*CW +: CW] = m_ctrl[i];
    return 32'(v);
  endfunction

  function automatic logic [31:0] addr_of(input int ch, input int r);
    return {24'd0, 4'(ch), 2'(r), 2'b00};
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  // Address phase, then data phase; returns 1 time unit after the closing edge
  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr_of(ch, r);
    step();
    bus_idle();
    HWDATA = d;
    step();
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr_of(ch, r);
    step();
    bus_idle();
    @(negedge HCLK);
    d = HRDATA;
    step();
  endtask

  task automatic read_check(input string tag, input int ch, input int r);
    logic [31:0] d;
    bus_read(ch, r, d);
    check(tag, d, model_read(ch, r));
  endtask

  task automatic set_info(input int ch, input logic [31:0] v);
    m_info[ch] = v;
    IO_BotInfo[ch*32 +: 32] = v;
  endtask

  task automatic pulse_updt(input int ch);
    IO_BotUpdt[ch] = 1'b1;
    repeat (3) step();
    IO_BotUpdt[ch] = 1'b0;
    repeat (3) step();
    model_edge(ch, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    int          chs_rd [5];
    int          chs_wr [4];
    chs_rd = '{0, 1, 2, 5, 15};
    chs_wr = '{0, 1, 3, 15};

    HRESETn = 1'b0; HADDR = '0; HWDATA = '0; HREADY = 1'b1;
    bus_idle();
    IO_BotUpdt = '0; IO_BotInfo = '0;
    for (int i = 0; i < NB; i++) m_info[i] = '0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    step();

    // Reset state
    check("rst IO_BotCtrl", 32'(IO_BotCtrl), 32'd0);
    check("rst IRQ", 32'(IRQ), 32'd0);
    check("rst IO_INT_ACK", 32'(IO_INT_ACK), 32'd0);
    check("rst HRDATA", HRDATA, 32'd0);
    check("HREADYOUT", 32'(HREADYOUT), 32'd1);
    check("HRESP", 32'(HRESP), 32'd0);
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        read_check($sformatf("rst rd c%0d r%0d", c, r), c, r);
    read_check("rst rd INTEN", 15, 0);

    // BOTCTRL ch1 write, truncated to CTRL_W bits
    bus_write(1, 1, 32'hABCD_1234);
    model_write(1, 1, 32'hABCD_1234);
    check("ctrl ch1 out", 32'(IO_BotCtrl[15:8]), 32'h34);
    check("ctrl ch0 untouched", 32'(IO_BotCtrl[7:0]), 32'h00);
    read_check("rd ctrl ch1", 1, 1);

    // BOTINFO and out-of-range channel
    set_info(0, 32'h1234_5678);
    set_info(1, 32'hCAFE_F00D);
    read_check("rd info ch0", 0, 0);
    check("rd info ch0 value", model_read(0, 0), 32'h1234_5678);
    read_check("rd info ch5", 5, 0);

    // Back-to-back write then read of the same register
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr_of(0, 1);
    step();
    HWDATA = 32'h0000_005A; HWRITE = 1'b0; HADDR = addr_of(0, 1);
    step();
    model_write(0, 1, 32'h5A);
    bus_idle();
    @(negedge HCLK);
    check("raw ctrl ch0", HRDATA, 32'h5A);
    step();

    // Enabled event on ch0: IRQ after exactly 3 edges, then ack
    bus_write(15, 0, 32'h1);
    model_write(15, 0, 32'h1);
    IO_BotUpdt[0] = 1'b1;
    step(); step();
    check("irq before 3 edges", 32'(IRQ), 32'd0);
    step();
    model_edge(0, 1'b0);
    check("irq after 3 edges", 32'(IRQ), 32'd1);
    IO_BotUpdt[0] = 1'b0;
    repeat (3) step();
    read_check("status ch0 pend", 0, 2);
    bus_write(0, 3, 32'h1);
    model_write(0, 3, 32'h1);
    check("ack pulse high", 32'(IO_INT_ACK), 32'b01);
    check("irq after ack", 32'(IRQ), 32'd0);
    step();
    check("ack pulse low", 32'(IO_INT_ACK), 32'b00);
    read_check("status ch0 cleared", 0, 2);

    // INTACK with bit0 = 0 is ignored
    pulse_updt(0);
    bus_write(0, 3, 32'hFFFF_FFFE);
    check("nop ack no pulse", 32'(IO_INT_ACK), 32'b00);
    read_check("status ch0 kept", 0, 2);
    bus_write(0, 3, 32'h1);
    model_write(0, 3, 32'h1);

    // Two edges on masked ch1: overrun, IRQ stays low until enabled
    pulse_updt(1);
    pulse_updt(1);
    read_check("status ch1 ovr", 1, 2);
    check("status ch1 value", model_read(1, 2), 32'd3);
    check("irq masked", 32'(IRQ), 32'd0);
    bus_write(15, 0, 32'h2);
    model_write(15, 0, 32'h2);
    check("irq unmasked", 32'(IRQ), 32'd1);

    // Ack and new edge on the same edge: set wins, overrun clears, pulse issued
    pulse_updt(0);
    pulse_updt(0);
    read_check("status ch0 pre-race", 0, 2);
    IO_BotUpdt[0] = 1'b1;
    step();
    bus_write(0, 3, 32'h1);
    model_edge(0, 1'b1);
    check("race ack pulse", 32'(IO_INT_ACK), 32'b01);
    step();
    check("race ack low", 32'(IO_INT_ACK), 32'b00);
    IO_BotUpdt[0] = 1'b0;
    repeat (3) step();
    read_check("race status ch0", 0, 2);
    check("race status value", model_read(0, 2), 32'd1);

    // INTEN = 0 masks IRQ but keeps pending
    bus_write(15, 0, 32'h0);
    model_write(15, 0, 32'h0);
    check("irq masked by inten", 32'(IRQ), 32'd0);
    read_check("pending retained", 1, 2);

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int op, ch, r;
      logic [31:0] v;
      op = int'($urandom_range(0, 4));
      r  = int'($urandom_range(0, 3));
      v  = $urandom;
      case (op)
        0: set_info(int'($urandom_range(0, NB-1)), v);
        1, 2: begin
          ch = chs_wr[$urandom_range(0, 3)];
          if (ch == 15 && $urandom_range(0, 1) == 1) r = 0;
          bus_write(ch, r, v);
          model_write(ch, r, v);
        end
        3: begin
          ch = chs_rd[$urandom_range(0, 4)];
          read_check($sformatf("rnd rd c%0d r%0d", ch, r), ch, r);
        end
        default: pulse_updt(int'($urandom_range(0, NB-1)));
      endcase
      check($sformatf("rnd ctrl it%0d", it), 32'(IO_BotCtrl), model_ctrl_bus());
      check($sformatf("rnd irq it%0d", it), 32'(IRQ), 32'(model_irq()));
    end

    // Reset pulse inside a write data phase: the write must not land
    bus_write(0, 1, 32'h33);
    model_write(0, 1, 32'h33);
    bus_write(15, 0, 32'h3);
    pulse_updt(1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr_of(1, 1);
    step();
    bus_idle();
    HWDATA = 32'h77;
    #1 HRESETn = 1'b0;
    #1;
    model_reset();
    check("mid rst ctrl", 32'(IO_BotCtrl), 32'd0);
    check("mid rst irq", 32'(IRQ), 32'd0);
    check("mid rst ack", 32'(IO_INT_ACK), 32'd0);
    check("mid rst hrdata", HRDATA, 32'd0);
    HRESETn = 1'b1;
    step();
    check("post rst no write", 32'(IO_BotCtrl), 32'd0);
    check("post rst no ack", 32'(IO_INT_ACK), 32'd0);
    read_check("post rst ctrl ch1", 1, 1);
    read_check("post rst status ch1", 1, 2);
    read_check("post rst inten", 15, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
